// File: rtl/data_slice.sv
// Registered 64-bit word to eight-lane splitter with optional byte-reverse lane order.
// Define DATA_SLICE_PARITY_EN to add the registered per-lane parity output o_par.
module data_slice #(
    parameter int LANE_W    = 8,
    parameter int RESET_VAL = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic                rev,
    input  logic [8*LANE_W-1:0] data_in,
    output logic                out_valid,
`ifdef DATA_SLICE_PARITY_EN
    output logic [7:0]          o_par,
`endif
    output logic [LANE_W-1:0]   o0,
    output logic [LANE_W-1:0]   o1,
    output logic [LANE_W-1:0]   o2,
    output logic [LANE_W-1:0]   o3,
    output logic [LANE_W-1:0]   o4,
    output logic [LANE_W-1:0]   o5,
    output logic [LANE_W-1:0]   o6,
    output logic [LANE_W-1:0]   o7
);

    localparam logic [LANE_W-1:0] RST_LANE = LANE_W'(RESET_VAL);

    logic [7:0][LANE_W-1:0] lane_d, lane_q;
    logic                   valid_d, valid_q;

    // Lanes only move on a capture; rev is looked at on that same edge and nowhere else.
    always_comb begin
        lane_d  = lane_q;
        valid_d = in_valid;
        if (in_valid) begin
            for (int k = 0; k < 8; k++) begin
                lane_d[k] = rev ? data_in[LANE_W*(7-k) +: LANE_W]
                                : data_in[LANE_W*k +: LANE_W];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane_q  <= {8{RST_LANE}};
            valid_q <= 1'b0;
        end else begin
            lane_q  <= lane_d;
            valid_q <= valid_d;
        end
    end

`ifdef DATA_SLICE_PARITY_EN
    logic [7:0] par_d, par_q;

    // Parity is taken from the value entering each lane so it stays aligned with the lane.
    always_comb begin
        par_d = par_q;
        if (in_valid) begin
            for (int k = 0; k < 8; k++) begin
                par_d[k] = ^lane_d[k];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_q <= {8{^RST_LANE}};
        end else begin
            par_q <= par_d;
        end
    end

    assign o_par = par_q;
`endif

    assign out_valid = valid_q;
    assign o0 = lane_q[0];
    assign o1 = lane_q[1];
    assign o2 = lane_q[2];
    assign o3 = lane_q[3];
    assign o4 = lane_q[4];
    assign o5 = lane_q[5];
    assign o6 = lane_q[6];
    assign o7 = lane_q[7];

endmodule

// File: tb/tb_data_slice.sv
// Directed self-checking bench for data_slice; parity checks compile in with DATA_SLICE_PARITY_EN.
module tb_data_slice;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        rev;
    logic [63:0] data_in;
    logic        out_valid;
    logic [7:0]  o0, o1, o2, o3, o4, o5, o6, o7;
`ifdef DATA_SLICE_PARITY_EN
    logic [7:0]  o_par;
`endif

    int checks   = 0;
    int failures = 0;

    data_slice #(.LANE_W(8), .RESET_VAL(0)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .rev       (rev),
        .data_in   (data_in),
        .out_valid (out_valid),
`ifdef DATA_SLICE_PARITY_EN
        .o_par     (o_par),
`endif
        .o0        (o0),
        .o1        (o1),
        .o2        (o2),
        .o3        (o3),
        .o4        (o4),
        .o5        (o5),
        .o6        (o6),
        .o7        (o7)
    );

    always #5 clk = ~clk;

    // Lanes packed o7..o0 so a rev=0 capture reads back as the original word.
    function automatic logic [63:0] lanes();
        return {o7, o6, o5, o4, o3, o2, o1, o0};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; rev = 1'b0; data_in = 64'h1122334455667788;
        #2;
        checks++;
        if (lanes() !== 64'h0 || out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_initial lanes=%h valid=%b expected lanes=0 valid=0", lanes(), out_valid);
        end
        step();
        checks++;
        if (lanes() !== 64'h0 || out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_held_edge lanes=%h valid=%b expected lanes=0 valid=0", lanes(), out_valid);
        end
        in_valid = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_normal();
        in_valid = 1'b1; rev = 1'b0; data_in = 64'h0102030405060708;
        step();
        in_valid = 1'b0;
        checks++;
        if (lanes() !== 64'h0102030405060708 || out_valid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL normal_slice lanes=%h valid=%b expected lanes=0102030405060708 valid=1", lanes(), out_valid);
        end
        checks++;
        if (o0 !== 8'h08 || o7 !== 8'h01) begin
            failures++;
            $display("[TB] FAIL normal_ends o0=%h o7=%h expected o0=08 o7=01", o0, o7);
        end
    endtask

    task automatic test_back_to_back();
        in_valid = 1'b1; rev = 1'b0; data_in = 64'h0807060504030201;
        step();
        checks++;
        if (lanes() !== 64'h0807060504030201 || out_valid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL b2b_first lanes=%h valid=%b expected lanes=0807060504030201 valid=1", lanes(), out_valid);
        end
        data_in = 64'h0A0B0C0D0E0F0908;
        step();
        checks++;
        if (o0 !== 8'h08 || o1 !== 8'h09 || o2 !== 8'h0F || o7 !== 8'h0A || out_valid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL b2b_second lanes=%h valid=%b expected lanes=0a0b0c0d0e0f0908 valid=1", lanes(), out_valid);
        end
    endtask

    task automatic test_hold();
        in_valid = 1'b0; data_in = 64'hFFFF_FFFF_FFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (lanes() !== 64'h0A0B0C0D0E0F0908 || out_valid !== 1'b0) begin
                failures++;
                $display("[TB] FAIL hold_%0d lanes=%h valid=%b expected lanes=0a0b0c0d0e0f0908 valid=0", i, lanes(), out_valid);
            end
        end
    endtask

    task automatic test_reverse();
        in_valid = 1'b1; rev = 1'b1; data_in = 64'h0102030405060708;
        step();
        in_valid = 1'b0;
        checks++;
        if (lanes() !== 64'h0807060504030201 || o0 !== 8'h01 || out_valid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reverse lanes=%h valid=%b expected lanes=0807060504030201 valid=1", lanes(), out_valid);
        end
        for (int i = 0; i < 3; i++) begin
            rev = ~rev;
            data_in = 64'h1122334455667788;
            step();
            checks++;
            if (lanes() !== 64'h0807060504030201 || out_valid !== 1'b0) begin
                failures++;
                $display("[TB] FAIL rev_toggle_%0d lanes=%h valid=%b expected lanes=0807060504030201 valid=0", i, lanes(), out_valid);
            end
        end
        rev = 1'b0;
    endtask

`ifdef DATA_SLICE_PARITY_EN
    task automatic test_parity();
        in_valid = 1'b1; rev = 1'b0; data_in = 64'h0000_0000_0000_0701;
        step();
        in_valid = 1'b0;
        checks++;
        if (o_par !== 8'b0000_0011) begin
            failures++;
            $display("[TB] FAIL parity_0701 o_par=%b expected 00000011", o_par);
        end
        step();
        checks++;
        if (o_par !== 8'b0000_0011) begin
            failures++;
            $display("[TB] FAIL parity_hold o_par=%b expected 00000011", o_par);
        end
        in_valid = 1'b1; rev = 1'b1; data_in = 64'h0000_0000_0000_0701;
        step();
        checks++;
        if (o_par !== 8'b1100_0000) begin
            failures++;
            $display("[TB] FAIL parity_rev o_par=%b expected 11000000", o_par);
        end
        rev = 1'b0; data_in = 64'h0;
        step();
        in_valid = 1'b0;
        checks++;
        if (o_par !== 8'h00) begin
            failures++;
            $display("[TB] FAIL parity_zero o_par=%b expected 00000000", o_par);
        end
    endtask
`endif

    task automatic test_async_reset();
        in_valid = 1'b1; rev = 1'b0; data_in = 64'h0807060504030201;
        step();
        checks++;
        if (lanes() !== 64'h0807060504030201) begin
            failures++;
            $display("[TB] FAIL async_preload lanes=%h expected 0807060504030201", lanes());
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (lanes() !== 64'h0 || out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL async_reset lanes=%h valid=%b expected lanes=0 valid=0", lanes(), out_valid);
        end
`ifdef DATA_SLICE_PARITY_EN
        checks++;
        if (o_par !== 8'h00) begin
            failures++;
            $display("[TB] FAIL async_reset_par o_par=%b expected 00000000", o_par);
        end
`endif
        #3;
        rst = 1'b0;
        data_in = 64'h1020304050607080;
        step();
        in_valid = 1'b0;
        checks++;
        if (lanes() !== 64'h1020304050607080 || out_valid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL post_reset_capture lanes=%h valid=%b expected lanes=1020304050607080 valid=1", lanes(), out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_back_to_back();
        test_hold();
        test_reverse();
`ifdef DATA_SLICE_PARITY_EN
        test_parity();
`endif
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_slice.md
Name: data_slice

Overview:
- Registered word-to-lane splitter: captures a 64-bit word and presents it as eight 8-bit lanes o0..o7.
- Sits between the NTT coefficient memory read port and the per-lane butterfly/coefficient datapath in the naive NTT core.
- Provides a one-cycle registered output with a valid flag, plus an optional byte-reverse mode for endian-swapped memory images.

Parameters:
- LANE_W, 8, width of each output lane in bits; the DATA_W input is fixed at 8*LANE_W.
- RESET_VAL, 0, value loaded into every lane register on reset, truncated to LANE_W.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  data_in is captured when high.
- rev  input  1  lane-order select, sampled together with data_in.
- data_in  input  8*LANE_W  packed input word.
- out_valid  output  1  high for the cycle after a capture.
- o0 through o7  output  LANE_W each  registered lanes.
- o_par  output  8  per-lane parity; present only with DATA_SLICE_PARITY_EN.

Behaviour:
- Reset (asynchronous, active-high, takes effect immediately, independent of clk):
  - o0..o7 = RESET_VAL.
  - out_valid = 0.
  - o_par = parity of RESET_VAL per lane, or 0 when RESET_VAL = 0.
- Reset asserted mid-operation discards any captured word. The first capture after release requires rst low at the clk edge.
- Capture happens at a rising clk edge with rst=0 and in_valid=1. Latency is 1 cycle: values appear after that edge.
- Lane mapping with rev=0: ok = data_in[LANE_W*k +: LANE_W], so o0 is the least-significant lane.
  - Example: 64'h0102030405060708 gives o0=08, o1=07, …, o7=01.
- Lane mapping with rev=1: ok = data_in[LANE_W*(7-k) +: LANE_W], so o0 is the most-significant lane.
- rev is sampled only on capture edges. Changing rev while in_valid=0 has no effect.
- With in_valid=0 at an edge:
  - Lane registers hold their previous values.
  - out_valid = 0.
- out_valid is a registered copy of in_valid, gated by reset.
  - Back-to-back in_valid=1 keeps out_valid high continuously and updates the lanes every cycle.
- No backpressure: the downstream block must consume data in the out_valid cycle, or read the held value later.
- Pure bit routing; no arithmetic. X on data_in propagates only into the lanes it maps to.

Optional Feature:
- Macro DATA_SLICE_PARITY_EN.
- When defined:
  - Output o_par[7:0] exists.
  - o_par[k] is the XOR-reduction of the value captured into ok.
  - It is registered in the same edge as ok, so latency is 1, and it holds when ok holds.
- When undefined:
  - Port o_par and all parity logic are absent.
  - All other behaviour is identical.

Test Plan:
- Reset: assert rst asynchronously mid-cycle with the lanes loaded, e.g. with 64'h0807060504030201 held → immediately all lanes = 00 and out_valid = 0.
- Normal slice: rev=0, in_valid=1, data_in=64'h0102030405060708 → next cycle o0..o7 = 08,07,06,05,04,03,02,01 and out_valid=1.
- Back-to-back stream: data_in=64'h0807060504030201 then 64'h0A0B0C0D0E0F0908 on consecutive edges.
  - Lanes go to 01,02,…,08, then to 08,09,0F,0E,0D,0C,0B,0A (o0..o7).
  - out_valid stays high throughout.
- Hold: after a capture, drop in_valid for 3 cycles while data_in changes to 64'hFFFF_FFFF_FFFF_FFFF → lanes are unchanged and out_valid = 0 on each of those cycles.
- Reverse: rev=1, data_in=64'h0102030405060708 → o0..o7 = 01,02,…,08. Toggling rev while in_valid=0 leaves the outputs unchanged.
- Parity (with DATA_SLICE_PARITY_EN): data_in=64'h0000_0000_0000_0701, rev=0 → o_par = 8'b0000_0011. All-zero input → o_par = 0.
